// File: rtl/inst_fetch_unit.sv
// IF-stage fetch engine.
// Receives the current fetch PC from the program counter and issues one instruction-memory
// request at a time. Returned instructions are buffered with their PCs in a 2-entry FIFO
// toward decode. mem_stall_o tells the program counter whether it may advance or redirect.
// A flush discards the response in flight and everything queued.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pc_i            current fetch PC
//   flush_i         redirect; the PC loads its new target at the next edge
//   mem_stall_o     1 = PC holds, 0 = PC advances (or redirects) at the next edge
//   imem_req_o      request valid, imem_addr_o = pc_i, imem_gnt_i completes the handshake
//   imem_rvalid_i   in-order read response carrying imem_rdata_i
//   if_valid_o      queue head valid, head data on if_inst_o / if_pc_o
//   id_ready_i      decode accepts the head
module inst_fetch_unit #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned QDEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_i,
   input  logic            flush_i,
   output logic            mem_stall_o,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_inst_o,
   output logic [XLEN-1:0] if_pc_o,
   input  logic            id_ready_i
);

   localparam logic [1:0] QFull = 2'(QDEPTH);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

   state_e          state_q;
   logic [1:0]      count_q;
   logic [XLEN-1:0] req_pc_q;
   logic [XLEN-1:0] e0_pc_q, e0_inst_q;  // queue head
   logic [XLEN-1:0] e1_pc_q, e1_inst_q;

   logic handshake;
   logic push;
   logic pop;

   // Never request with a full queue, so every response is guaranteed a slot.
   assign imem_req_o  = (state_q == StReq) && (count_q != QFull);
   assign imem_addr_o = pc_i;
   assign handshake   = imem_req_o & imem_gnt_i;

   assign push = (state_q == StWait) & imem_rvalid_i & ~flush_i;

   // Flush always releases the PC so a redirect is never lost.
   assign mem_stall_o = ~flush_i & ~((state_q == StWait) & imem_rvalid_i);

   assign if_valid_o = (count_q != 2'd0) & ~flush_i;
   assign pop        = if_valid_o & id_ready_i;
   assign if_inst_o  = e0_inst_q;
   assign if_pc_o    = e0_pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         count_q   <= 2'd0;
         req_pc_q  <= '0;
         e0_pc_q   <= '0;
         e0_inst_q <= '0;
         e1_pc_q   <= '0;
         e1_inst_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: state_q <= StReq;
            StReq: begin
               if (handshake) begin
                  req_pc_q <= pc_i;
                  // A flush in the grant cycle makes this response stale.
                  state_q  <= flush_i ? StDrop : StWait;
               end
            end
            StWait: begin
               if (imem_rvalid_i) begin
                  state_q <= StReq;
               end else if (flush_i) begin
                  state_q <= StDrop;
               end
            end
            StDrop: begin
               if (imem_rvalid_i) begin
                  state_q <= StReq;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (flush_i) begin
            count_q <= 2'd0;
         end else begin
            case ({push, pop})
               2'b10: begin
                  if (count_q == 2'd0) begin
                     e0_pc_q   <= req_pc_q;
                     e0_inst_q <= imem_rdata_i;
                  end else begin
                     e1_pc_q   <= req_pc_q;
                     e1_inst_q <= imem_rdata_i;
                  end
                  count_q <= count_q + 2'd1;
               end
               2'b01: begin
                  // With one entry left the head keeps its last value.
                  if (count_q == 2'd2) begin
                     e0_pc_q   <= e1_pc_q;
                     e0_inst_q <= e1_inst_q;
                  end
                  count_q <= count_q - 2'd1;
               end
               2'b11: begin
                  if (count_q == 2'd2) begin
                     e0_pc_q   <= e1_pc_q;
                     e0_inst_q <= e1_inst_q;
                     e1_pc_q   <= req_pc_q;
                     e1_inst_q <= imem_rdata_i;
                  end else begin
                     e0_pc_q   <= req_pc_q;
                     e0_inst_q <= imem_rdata_i;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   push_into_full: assert property (@(posedge clk) disable iff (rst) !(push && count_q == QFull));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: program-counter model, latency-programmable memory model and
// a scoreboard of expected decode deliveries.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_i;
   logic        flush_i;
   logic        mem_stall_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        if_valid_o;
   logic [31:0] if_inst_o;
   logic [31:0] if_pc_o;
   logic        id_ready_i;

   inst_fetch_unit #(.XLEN(32), .QDEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .flush_i       (flush_i),
      .mem_stall_o   (mem_stall_o),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_valid_o    (if_valid_o),
      .if_inst_o     (if_inst_o),
      .if_pc_o       (if_pc_o),
      .id_ready_i    (id_ready_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   del_cnt = 0;

   // Bench controls
   logic        flush = 1'b0;
   logic [31:0] flush_target = '0;
   logic        id_ready = 1'b0;
   logic        gnt_en = 1'b1;
   logic [31:0] gnt_limit = 32'hffff_ffff;
   int          lat = 1;
   logic        mem_clear = 1'b1;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return 32'h13 + (pc << 8);
   endfunction

   function automatic exp_t mk(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.inst = inst_of(pc);
      return e;
   endfunction

   assign flush_i    = flush;
   assign id_ready_i = id_ready;
   assign imem_gnt_i = gnt_en && (imem_addr_o < gnt_limit);

   // Program counter: reset to 0, redirect on flush, +4 when not stalled.
   logic [31:0] pc_model;
   int          adv_cnt;
   assign pc_i = pc_model;
   always @(posedge clk) begin
      if (rst) begin
         pc_model <= '0;
         adv_cnt  <= 0;
      end else if (flush) begin
         pc_model <= flush_target;
      end else if (!mem_stall_o) begin
         pc_model <= pc_model + 32'd4;
         adv_cnt  <= adv_cnt + 1;
      end
   end

   // Memory: one outstanding request, response lat cycles after the grant.
   logic        mem_pend = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   always @(posedge clk) begin
      if (mem_clear || imem_rvalid_i) begin
         mem_pend <= 1'b0;
      end else if (imem_req_o && imem_gnt_i) begin
         mem_pend <= 1'b1;
         mem_addr <= imem_addr_o;
         mem_cnt  <= lat - 1;
      end else if (mem_pend && mem_cnt > 0) begin
         mem_cnt <= mem_cnt - 1;
      end
   end
   assign imem_rvalid_i = mem_pend && (mem_cnt == 0);
   assign imem_rdata_i  = mem_pend ? inst_of(mem_addr) : 32'hdead_beef;

   // Sample at the falling edge; any decode transfer is checked against the scoreboard.
   task automatic sample();
      exp_t e;
      @(negedge clk);
      if (!rst && if_valid_o === 1'b1 && id_ready) begin
         del_cnt++;
         total_cnt++;
         if (sb.size() == 0) begin
            $display("FAIL deliver: got pc %h inst %h, required no delivery", if_pc_o, if_inst_o);
         end else begin
            e = sb.pop_front();
            if ({if_pc_o, if_inst_o} !== {e.pc, e.inst})
               $display("FAIL deliver: got pc %h inst %h, required pc %h inst %h",
                        if_pc_o, if_inst_o, e.pc, e.inst);
            else pass_cnt++;
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      mem_clear = 1'b1;
      flush     = 1'b0;
      id_ready  = 1'b0;
      gnt_en    = 1'b1;
      gnt_limit = 32'hffff_ffff;
      lat       = 1;
      sb.delete();
      repeat (2) begin
         sample();
         advance();
      end
      rst       = 1'b0;
      mem_clear = 1'b0;
      del_cnt   = 0;
   endtask

   // Run until a handshake to addr is seen, ending just after that edge.
   task automatic wait_hs(input logic [31:0] addr, input string name);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         sample();
         hit = imem_req_o && imem_gnt_i && (imem_addr_o == addr);
         advance();
      end
      total_cnt++;
      if (!hit) $display("FAIL %s: no handshake, required request to %h", name, addr);
      else pass_cnt++;
   endtask

   task automatic wait_first_req(input logic [31:0] addr, input string name);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         sample();
         if (imem_req_o === 1'b1) begin
            found = 1'b1;
            total_cnt++;
            if (imem_addr_o !== addr)
               $display("FAIL %s: got addr %h, required %h", name, imem_addr_o, addr);
            else pass_cnt++;
         end
         advance();
      end
      if (!found) begin
         total_cnt++;
         $display("FAIL %s: no request, required request to %h", name, addr);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 80 && sb.size() != 0; i++) begin
         sample();
         advance();
      end
      repeat (4) begin
         sample();
         advance();
      end
      total_cnt++;
      if (sb.size() != 0) $display("FAIL %s: got %0d pending, required 0", name, sb.size());
      else pass_cnt++;
   endtask

   task automatic test_reset();
      do_reset();
      sample();
      total_cnt++;
      if ({imem_req_o, mem_stall_o, if_valid_o} !== 3'b010)
         $display("FAIL reset_ctl: got req/stall/valid %b, required 010",
                  {imem_req_o, mem_stall_o, if_valid_o});
      else pass_cnt++;
      total_cnt++;
      if ({if_pc_o, if_inst_o} !== 64'h0)
         $display("FAIL reset_head: got %h, required 0", {if_pc_o, if_inst_o});
      else pass_cnt++;
      advance();
   endtask

   task automatic test_first_fetch();
      do_reset();
      sample();
      total_cnt++;
      if ({imem_req_o, mem_stall_o} !== 2'b01)
         $display("FAIL ff_c0: got req/stall %b, required 01", {imem_req_o, mem_stall_o});
      else pass_cnt++;
      advance();
      sample();
      total_cnt++;
      if ({imem_req_o, mem_stall_o, imem_addr_o} !== {2'b11, 32'h0})
         $display("FAIL ff_c1: got req/stall/addr %b %h, required 11 0",
                  {imem_req_o, mem_stall_o}, imem_addr_o);
      else pass_cnt++;
      advance();
      sample();
      total_cnt++;
      if ({imem_req_o, mem_stall_o} !== 2'b00)
         $display("FAIL ff_c2: got req/stall %b, required 00", {imem_req_o, mem_stall_o});
      else pass_cnt++;
      advance();
      sample();
      total_cnt++;
      if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h0, 32'h13})
         $display("FAIL ff_head: got %b %h %h, required 1 0 13", if_valid_o, if_pc_o, if_inst_o);
      else pass_cnt++;
      advance();
   endtask

   task automatic test_straight_line();
      do_reset();
      gnt_limit = 32'd12;
      id_ready  = 1'b1;
      sb.push_back(mk(32'd0));
      sb.push_back(mk(32'd4));
      sb.push_back(mk(32'd8));
      drain("sl_drain");
      total_cnt++;
      if (del_cnt !== 3 || adv_cnt !== 3 || pc_model !== 32'd12)
         $display("FAIL sl_count: got del %0d adv %0d pc %h, required 3 3 0000000c",
                  del_cnt, adv_cnt, pc_model);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      do_reset();
      gnt_limit = 32'd12;
      sb.push_back(mk(32'd0));
      sb.push_back(mk(32'd4));
      sb.push_back(mk(32'd8));
      repeat (10) begin
         sample();
         advance();
      end
      sample();
      total_cnt++;
      if ({imem_req_o, mem_stall_o, if_valid_o} !== 3'b011)
         $display("FAIL bp_full: got req/stall/valid %b, required 011",
                  {imem_req_o, mem_stall_o, if_valid_o});
      else pass_cnt++;
      total_cnt++;
      if (if_pc_o !== 32'd0 || pc_model !== 32'd8)
         $display("FAIL bp_head: got head %h pc %h, required 0 8", if_pc_o, pc_model);
      else pass_cnt++;
      advance();
      id_ready = 1'b1;
      wait_first_req(32'd8, "bp_resume");
      drain("bp_drain");
      total_cnt++;
      if (adv_cnt !== 3) $display("FAIL bp_adv: got %0d, required 3", adv_cnt);
      else pass_cnt++;
   endtask

   task automatic test_flush_wait();
      do_reset();
      lat = 3;
      wait_hs(32'd4, "fw_hs");
      flush        = 1'b1;
      flush_target = 32'h100;
      sample();
      total_cnt++;
      if ({mem_stall_o, if_valid_o} !== 2'b00)
         $display("FAIL fw_flush: got stall/valid %b, required 00", {mem_stall_o, if_valid_o});
      else pass_cnt++;
      advance();
      flush     = 1'b0;
      id_ready  = 1'b1;
      gnt_limit = 32'h104;
      sb.push_back(mk(32'h100));
      sample();
      total_cnt++;
      if ({mem_stall_o, if_valid_o} !== 2'b10)
         $display("FAIL fw_drop: got stall/valid %b, required 10", {mem_stall_o, if_valid_o});
      else pass_cnt++;
      advance();
      wait_first_req(32'h100, "fw_target");
      drain("fw_drain");
      total_cnt++;
      if (adv_cnt !== 2 || pc_model !== 32'h104)
         $display("FAIL fw_adv: got adv %0d pc %h, required 2 00000104", adv_cnt, pc_model);
      else pass_cnt++;
   endtask

   task automatic test_flush_rvalid();
      do_reset();
      id_ready = 1'b1;
      wait_hs(32'd0, "fr_hs");
      flush        = 1'b1;
      flush_target = 32'h200;
      lat          = 3;
      sample();
      total_cnt++;
      if ({mem_stall_o, if_valid_o} !== 2'b00)
         $display("FAIL fr_flush: got stall/valid %b, required 00", {mem_stall_o, if_valid_o});
      else pass_cnt++;
      advance();
      flush = 1'b0;
      sample();
      total_cnt++;
      if ({imem_req_o, if_valid_o, imem_addr_o} !== {2'b10, 32'h200})
         $display("FAIL fr_nopush: got req/valid %b addr %h, required 10 00000200",
                  {imem_req_o, if_valid_o}, imem_addr_o);
      else pass_cnt++;
      advance();
      flush        = 1'b1;
      flush_target = 32'h300;
      sample();
      advance();
      flush_target = 32'h400;
      gnt_limit    = 32'h404;
      sb.push_back(mk(32'h400));
      sample();
      total_cnt++;
      if (mem_stall_o !== 1'b0) $display("FAIL fr_drop_flush: got stall %b, required 0", mem_stall_o);
      else pass_cnt++;
      advance();
      flush = 1'b0;
      wait_first_req(32'h400, "fr_target");
      drain("fr_drain");
      total_cnt++;
      if (adv_cnt !== 1 || pc_model !== 32'h404)
         $display("FAIL fr_adv: got adv %0d pc %h, required 1 00000404", adv_cnt, pc_model);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      lat      = 2;
      id_ready = 1'b1;
      wait_hs(32'd0, "rm_hs");
      rst = 1'b1;
      sample();
      advance();
      rst       = 1'b0;
      gnt_limit = 32'd4;
      sb.push_back(mk(32'd0));
      sample();
      total_cnt++;
      if ({imem_req_o, if_valid_o, mem_stall_o} !== 3'b001)
         $display("FAIL rm_idle: got req/valid/stall %b, required 001",
                  {imem_req_o, if_valid_o, mem_stall_o});
      else pass_cnt++;
      advance();
      sample();
      total_cnt++;
      if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0})
         $display("FAIL rm_req: got req %b addr %h, required 1 0", imem_req_o, imem_addr_o);
      else pass_cnt++;
      advance();
      drain("rm_drain");
      total_cnt++;
      if (del_cnt !== 1 || adv_cnt !== 1)
         $display("FAIL rm_count: got del %0d adv %0d, required 1 1", del_cnt, adv_cnt);
      else pass_cnt++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      #1;
      test_reset();
      test_first_fetch();
      test_straight_line();
      test_backpressure();
      test_flush_wait();
      test_flush_rvalid();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
